// File: rtl/ls_seq_pkg.sv
// Shared constants and types for the D-format load/store sequencer.
// Opcode encodings, FSM states and control-field codes.
package ls_seq_pkg;

    localparam logic [10:0] OP_STUR   = 11'b11111000000;
    localparam logic [10:0] OP_LDUR   = 11'b11111000010;
    localparam logic [10:0] OP_STURW  = 11'b10111000000;
    localparam logic [10:0] OP_LDURSW = 11'b10111000100;
    localparam logic [10:0] OP_STURH  = 11'b01111000000;
    localparam logic [10:0] OP_LDURH  = 11'b01111000010;
    localparam logic [10:0] OP_STURB  = 11'b00111000000;
    localparam logic [10:0] OP_LDURB  = 11'b00111000010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACCESS,
        S_WB,
        S_DONE,
        S_FAULT
    } state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] MEM_CS_OFF = 2'b00;
    localparam logic [1:0] MEM_CS_ON  = 2'b01;

    localparam logic [1:0] DTS_NONE = 2'b00;
    localparam logic [1:0] DTS_REGB = 2'b01;
    localparam logic [1:0] DTS_MEM  = 2'b10;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC4 = 2'b01;

    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] XZR    = 5'd31;

endpackage

// File: rtl/ls_opcode_decode.sv
// D-format opcode classifier: validity, direction, access size.
// Doubleword opcodes are rejected on a 32-bit datapath.
module ls_opcode_decode
    import ls_seq_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [10:0] opcode_i,
    output logic        valid_o,
    output logic        is_load_o,
    output logic [1:0]  size_o,
    output logic        sign_ext_o
);

    localparam bit DW64 = (DATA_W == 64);

    always_comb begin
        valid_o    = 1'b0;
        is_load_o  = 1'b0;
        size_o     = SZ_B;
        sign_ext_o = 1'b0;
        unique case (opcode_i)
            OP_STUR: begin
                valid_o = DW64;
                size_o  = SZ_D;
            end
            OP_LDUR: begin
                valid_o   = DW64;
                is_load_o = 1'b1;
                size_o    = SZ_D;
            end
            OP_STURW: begin
                valid_o = 1'b1;
                size_o  = SZ_W;
            end
            OP_LDURSW: begin
                valid_o    = 1'b1;
                is_load_o  = 1'b1;
                size_o     = SZ_W;
                sign_ext_o = 1'b1;
            end
            OP_STURH: begin
                valid_o = 1'b1;
                size_o  = SZ_H;
            end
            OP_LDURH: begin
                valid_o   = 1'b1;
                is_load_o = 1'b1;
                size_o    = SZ_H;
            end
            OP_STURB: begin
                valid_o = 1'b1;
                size_o  = SZ_B;
            end
            OP_LDURB: begin
                valid_o   = 1'b1;
                is_load_o = 1'b1;
                size_o    = SZ_B;
            end
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ls_sequencer.sv
// Multicycle load/store sequencer with mem_ready handshake and
// bounded wait; all control fields are Moore-decoded.
module ls_sequencer
    import ls_seq_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = $clog2(WAIT_MAX + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       IR,
    input  logic              mem_ready,
    output logic [4:0]        SA,
    output logic [4:0]        SB,
    output logic [4:0]        DA,
    output logic [DATA_W-1:0] k,
    output logic [4:0]        FS,
    output logic              B_Sel,
    output logic              w_reg,
    output logic [1:0]        mem_cs,
    output logic              mem_write_en,
    output logic [1:0]        size,
    output logic              sign_ext,
    output logic              add_tri_sel,
    output logic [1:0]        data_tri_sel,
    output logic [1:0]        PC_FS,
    output logic              busy,
    output logic              done,
    output logic              fault
);

    state_e            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [10:0] dec_op;
    logic        dec_valid;
    logic        dec_load;
    logic [1:0]  dec_size;
    logic        dec_sext;

    logic [4:0]  rn;
    logic [4:0]  rt;
    logic        unused_ir;

    // IDLE classifies the incoming IR; later states the captured one
    assign dec_op = (state_q == S_IDLE) ? IR[31:21] : ir_q[31:21];

    ls_opcode_decode #(
        .DATA_W (DATA_W)
    ) u_dec (
        .opcode_i   (dec_op),
        .valid_o    (dec_valid),
        .is_load_o  (dec_load),
        .size_o     (dec_size),
        .sign_ext_o (dec_sext)
    );

    assign rn        = ir_q[9:5];
    assign rt        = ir_q[4:0];
    assign unused_ir = ^ir_q[11:10];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ir_d    = IR;
                    state_d = dec_valid ? S_ADDR : S_FAULT;
                end
            end
            S_ADDR: state_d = S_ACCESS;
            S_ACCESS: begin
                if (mem_ready) begin
                    cnt_d   = '0;
                    state_d = dec_load ? S_WB : S_DONE;
                end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        SA           = '0;
        SB           = '0;
        DA           = '0;
        k            = '0;
        FS           = '0;
        B_Sel        = 1'b0;
        w_reg        = 1'b0;
        mem_cs       = MEM_CS_OFF;
        mem_write_en = 1'b0;
        size         = SZ_B;
        sign_ext     = 1'b0;
        add_tri_sel  = 1'b0;
        data_tri_sel = DTS_NONE;
        PC_FS        = PC_HOLD;
        busy         = (state_q != S_IDLE);
        done         = 1'b0;
        fault        = 1'b0;
        // address path stays driven through WB while the read is returned
        if (state_q == S_ADDR || state_q == S_ACCESS || state_q == S_WB) begin
            SA          = rn;
            B_Sel       = 1'b1;
            FS          = FS_ADD;
            k           = {{(DATA_W-9){ir_q[20]}}, ir_q[20:12]};
            add_tri_sel = 1'b1;
        end
        unique case (state_q)
            S_ACCESS: begin
                mem_cs = MEM_CS_ON;
                size   = dec_size;
                if (!dec_load) begin
                    SB           = rt;
                    data_tri_sel = DTS_REGB;
                    mem_write_en = 1'b1;
                end
            end
            S_WB: begin
                mem_cs       = MEM_CS_ON;
                size         = dec_size;
                DA           = rt;
                data_tri_sel = DTS_MEM;
                sign_ext     = dec_sext;
                w_reg        = (rt != XZR);
            end
            S_DONE: begin
                done  = 1'b1;
                PC_FS = PC_INC4;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/ls_sequencer.md
Name: ls_sequencer

Overview:
Parametrised multicycle load/store sequencer that replaces the fixed-timing load/store next-state logic inside the control unit. It takes an IR for any LEGv8 D-format instruction and drives the register-file, ALU, memory and tri-state control fields. Memory access waits on a mem_ready handshake with a bounded timeout. Byte, half, word and doubleword sizes are supported, with sign-extending LDURSW, selected by DATA_W. The control unit's state decoder instantiates it and raises start when a D-format opcode is fetched.

Parameters:
DATA_W, 64, datapath width; 32 or 64; with 32, doubleword opcodes are invalid.
WAIT_MAX, 15, maximum ACCESS cycles without mem_ready before fault.
CNT_W, $clog2(WAIT_MAX+1), wait-counter width (derived).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin sequence; sampled only in IDLE
IR  in  32  instruction; captured on the accepting edge
mem_ready  in  1  memory completed the access this cycle
SA  out  5  base register Rn
SB  out  5  store-data register Rt
DA  out  5  load destination Rt
k  out  DATA_W  sign-extended DT_address IR[20:12]
FS  out  5  ALU function; FS_ADD during ADDR and ACCESS
B_Sel  out  1  1 = ALU B from k
w_reg  out  1  register write enable
mem_cs  out  2  memory chip select (MEM_CS_ON = 2'b01)
mem_write_en  out  1  store strobe
size  out  2  00 byte, 01 half, 10 word, 11 double
sign_ext  out  1  sign-extend load data (LDURSW)
add_tri_sel  out  1  ALU result drives address bus
data_tri_sel  out  2  data bus source: 00 none, 01 register B, 10 memory
PC_FS  out  2  00 hold, 01 PC+4
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle completion pulse
fault  out  1  one-cycle error pulse

Behaviour:
- Reset (asynchronous, active-low): state IDLE, IR register 0, counter 0. Every output is 0 immediately, with no clock edge needed.
- Outputs are Moore-decoded from the state and the captured IR. No output depends combinationally on start or mem_ready.
- Decode of IR[31:21]:
  - STUR/LDUR 11111000000/11111000010, size 11
  - STURW/LDURSW 10111000000/10111000100, size 10; LDURSW sets sign_ext
  - STURH/LDURH 01111000000/01111000010, size 01
  - STURB/LDURB 00111000000/00111000010, size 00
  - Any other opcode is invalid. Size 11 is also invalid when DATA_W==32.
- IDLE: when start=1, capture IR. A valid opcode goes to ADDR; an invalid one goes to FAULT.
- ADDR (1 cycle): SA=Rn, B_Sel=1, FS=FS_ADD, k valid, add_tri_sel=1.
- ACCESS: ADDR outputs are held, plus mem_cs=MEM_CS_ON and size valid.
  - Stores also assert SB=Rt, data_tri_sel=01 and mem_write_en=1.
  - The counter increments each cycle with mem_ready=0.
  - mem_ready=1: a load goes to WB, a store goes to DONE, and the counter clears.
  - Counter == WAIT_MAX-1 with mem_ready=0: go to FAULT. mem_ready on that same cycle wins.
- WB (loads only, 1 cycle): DA=Rt, data_tri_sel=10, sign_ext per opcode, mem_cs held. w_reg=1 unless Rt==31 (XZR), in which case w_reg=0.
- DONE (1 cycle): done=1, PC_FS=01, then IDLE. start is ignored in this cycle.
- FAULT (1 cycle): fault=1, PC_FS=00, mem_cs=0, then IDLE.
- Latency from the start edge with mem_ready=1 on the first ACCESS cycle:
  - store: done 3 cycles later
  - load: done 4 cycles later
  - each wait cycle adds 1
- The captured IR is held for the whole sequence. Changes on the IR input after acceptance have no effect.

Decomposition:
- Package ls_seq_pkg holds:
  - the opcode constants
  - the state enum (IDLE, ADDR, ACCESS, WB, DONE, FAULT)
  - size, MEM_CS, data_tri_sel and PC_FS codes
  - FS_ADD
- One combinational sub-module, ls_opcode_decode, parametrised by DATA_W. It maps opcode to valid, is_load, size and sign_ext.

Test Plan:
- STUR X0,[X1,#1], IR=32'hF8001020, start, mem_ready=1 in the first ACCESS cycle:
  - ADDR: SA=1, k=1, B_Sel=1.
  - ACCESS: SB=0, mem_write_en=1, size=11, data_tri_sel=01.
  - done pulses 3 cycles after start; w_reg never 1.
- LDURB X2,[X3,#-1], IR=32'h385FF062, mem_ready after 2 wait cycles:
  - k=64'hFFFF_FFFF_FFFF_FFFF, busy held 6 cycles.
  - WB: DA=2, w_reg=1, size=00, sign_ext=0.
  - done 6 cycles after start.
- STUR with mem_ready held 0:
  - exactly 15 ACCESS cycles, then fault=1 for 1 cycle and mem_cs=0.
  - done never asserted; back in IDLE.
- Invalid IR=32'h8B020020 (ADD) with start: fault 1 cycle later, no mem_cs or w_reg activity. DATA_W=32 instance with LDUR: fault.
- DATA_W=32 instance, LDURSW with Rt=31: size=10, sign_ext=1, w_reg=0 in WB, done asserted.
- reset driven low mid-ACCESS between clock edges: all outputs 0 at once. A subsequent STUR completes normally in 3 cycles.
